// File: rtl/oam_dma_ctrl.sv
// Sprite DMA sequencer: halts the CPU on a store to DMA_REG_ADDR and copies one page to OAM_DATA_ADDR.
// First DMA write 3-4 cycles after the trigger; CPU held via cpu_rdy for 1+2*XFER_LEN (+1 if realigning) cycles.
module oam_dma_ctrl #(
   parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
   parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
   parameter int unsigned XFER_LEN      = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_d_out,
   input  logic        cpu_we,
   input  logic [7:0]  bus_d_in,
   output logic        cpu_rdy,
   output logic [15:0] bus_addr,
   output logic [7:0]  bus_d_out,
   output logic        bus_we,
   output logic        dma_busy,
   output logic        dma_done
);

   typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

   localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

   state_t     state;
   logic [7:0] page;
   logic [7:0] idx;
   logic [7:0] data_reg;
   logic       parity;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         page     <= '0;
         idx      <= '0;
         data_reg <= '0;
         parity   <= 1'b0;
         dma_done <= 1'b0;
      end else begin
         parity   <= ~parity;
         dma_done <= 1'b0;
         case (state)
            IDLE: begin
               if (cpu_we && (cpu_addr == DMA_REG_ADDR)) begin
                  page  <= cpu_d_out;
                  idx   <= '0;
                  state <= HALT;
               end
            end
            // parity flips every cycle, so parity==1 now means the next cycle lands on 0
            HALT:  state <= parity ? READ : ALIGN;
            ALIGN: state <= READ;
            READ: begin
               data_reg <= bus_d_in;
               state    <= WRITE;
            end
            WRITE: begin
               idx <= idx + 8'd1;
               if (idx == LAST_IDX) begin
                  state    <= IDLE;
                  dma_done <= 1'b1;
               end else begin
                  state <= READ;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      bus_addr  = cpu_addr;
      bus_d_out = cpu_d_out;
      bus_we    = cpu_we;
      case (state)
         IDLE: ;
         READ: begin
            bus_addr = {page, idx};
            bus_we   = 1'b0;
         end
         WRITE: begin
            bus_addr  = OAM_DATA_ADDR;
            bus_d_out = data_reg;
            bus_we    = 1'b1;
         end
         // HALT/ALIGN: dummy CPU-address reads, CPU stores are blocked
         default: bus_we = 1'b0;
      endcase
   end

   assign cpu_rdy  = (state == IDLE);
   assign dma_busy = ~cpu_rdy;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Scoreboard bench for oam_dma_ctrl: expected OAM writes are queued at each trigger and popped per DMA write.
module tb_oam_dma_ctrl;

   localparam logic [15:0] DMA = 16'h4014;
   localparam logic [15:0] OAM = 16'h2004;

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  dat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] cpu_addr = '0;
   logic [7:0]  cpu_d_out = '0;
   logic        cpu_we = 1'b0;
   logic [7:0]  bus_d_in;
   logic        cpu_rdy;
   logic [15:0] bus_addr;
   logic [7:0]  bus_d_out;
   logic        bus_we;
   logic        dma_busy;
   logic        dma_done;

   int checks = 0;
   int errors = 0;
   int writes = 0;
   int done_cnt = 0;
   int halt_cnt = 0;
   logic        tpar;
   logic [15:0] prev_addr = '0;
   exp_t        sb[$];
   int          len_q[$];

   always #5 clk = ~clk;

   oam_dma_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_addr  (cpu_addr),
      .cpu_d_out (cpu_d_out),
      .cpu_we    (cpu_we),
      .bus_d_in  (bus_d_in),
      .cpu_rdy   (cpu_rdy),
      .bus_addr  (bus_addr),
      .bus_d_out (bus_d_out),
      .bus_we    (bus_we),
      .dma_busy  (dma_busy),
      .dma_done  (dma_done)
   );

   function automatic logic [7:0] mem(input logic [15:0] a);
      return (a[7:0] * 8'd7) ^ a[15:8] ^ 8'h3C;
   endfunction

   assign bus_d_in = mem(bus_addr);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference phase: 0 in the first cycle after reset release, then alternating
   always @(posedge clk or negedge rst) begin
      if (!rst) tpar <= 1'b0;
      else      tpar <= ~tpar;
   end

   always @(negedge clk) begin
      if (!rst) begin
         halt_cnt = 0;
         chk("rst_flags", 32'({cpu_rdy, dma_busy, dma_done}), 32'(3'b100));
         chk("rst_pass", 32'({bus_addr, bus_d_out, bus_we}), 32'({cpu_addr, cpu_d_out, cpu_we}));
      end else begin
         if (!dma_busy) begin
            chk("idle_pass", 32'({cpu_rdy, bus_addr, bus_d_out, bus_we}),
                32'({1'b1, cpu_addr, cpu_d_out, cpu_we}));
         end else begin
            halt_cnt++;
            chk("busy_rdy", 32'(cpu_rdy), 32'(0));
            if (bus_we) begin
               writes++;
               chk("wr_addr", 32'(bus_addr), 32'(OAM));
               chk("rd_par", 32'(tpar), 32'(1));
               chk("sb_avail", 32'(sb.size() > 0), 32'(1));
               if (sb.size() > 0) begin
                  exp_t e;
                  e = sb.pop_front();
                  chk("rd_addr", 32'(prev_addr), 32'(e.addr));
                  chk("wr_dat", 32'(bus_d_out), 32'(e.dat));
               end
            end
         end
         if (dma_done) begin
            done_cnt++;
            chk("len_avail", 32'(len_q.size() > 0), 32'(1));
            if (len_q.size() > 0) chk("halt_len", 32'(halt_cnt), 32'(len_q.pop_front()));
            chk("done_rdy", 32'(cpu_rdy), 32'(1));
            chk("sb_empty", 32'(sb.size()), 32'(0));
            halt_cnt = 0;
         end
      end
      prev_addr = bus_addr;
   end

   // Drive a trigger in the current cycle; expectations are queued once the trigger edge has passed
   task automatic start(input logic [7:0] pg);
      logic tp;
      cpu_addr  = DMA;
      cpu_d_out = pg;
      cpu_we    = 1'b1;
      tp        = tpar;
      @(posedge clk);
      for (int i = 0; i < 256; i++) begin
         exp_t e;
         e.addr = {pg, 8'(i)};
         e.dat  = mem(e.addr);
         sb.push_back(e);
      end
      len_q.push_back(tp ? 514 : 513);
      #1;
      cpu_we   = 1'b0;
      cpu_addr = 16'h0123;
   endtask

   task automatic trig(input logic [7:0] pg, input logic want_tp);
      int n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (tpar != want_tp && n < 10);
      start(pg);
   endtask

   task automatic wait_done();
      bit seen = 0;
      for (int n = 0; n < 1500 && !seen; n++) begin
         @(posedge clk);
         #1;
         if (dma_done) seen = 1;
      end
      chk("done_seen", 32'(seen), 32'(1));
   endtask

   initial begin
      int base;
      int n;
      // Reset with random CPU activity
      repeat (2) begin
         @(posedge clk);
         #1;
         cpu_addr  = 16'($urandom);
         cpu_d_out = 8'($urandom);
         cpu_we    = 1'($urandom);
      end
      @(posedge clk);
      #1;
      cpu_we   = 1'b0;
      cpu_addr = 16'h0100;
      rst      = 1'b1;

      // Ordinary store elsewhere in IDLE must not start a transfer
      cpu_addr  = 16'h4015;
      cpu_d_out = 8'hAA;
      cpu_we    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      cpu_we = 1'b0;
      chk("no_trig", 32'(dma_busy), 32'(0));

      // Even-aligned (no ALIGN, 513 cycles)
      trig(8'h02, 1'b0);
      wait_done();
      @(posedge clk);
      #1;
      chk("rdy_after", 32'(cpu_rdy), 32'(1));

      // Odd-aligned (ALIGN, 514 cycles)
      trig(8'h02, 1'b1);
      wait_done();

      // Spurious DMA-register stores while busy
      trig(8'h02, 1'b0);
      cpu_addr  = DMA;
      cpu_d_out = 8'h07;
      cpu_we    = 1'b1;
      repeat (100) @(posedge clk);
      #1;
      cpu_we   = 1'b0;
      cpu_addr = 16'h0123;
      wait_done();

      // Reset abort after the 100th OAM write
      base = writes;
      trig(8'h05, 1'b1);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (writes < base + 100 && n < 1000);
      rst = 1'b0;
      sb.delete();
      len_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("abort_wr", 32'(writes), 32'(base + 100));
      chk("abort_idle", 32'(dma_busy), 32'(0));
      trig(8'h03, 1'b0);
      wait_done();

      // Top page, then retrigger in the dma_done cycle
      trig(8'hFF, 1'b1);
      wait_done();
      start(8'h01);
      wait_done();
      @(posedge clk);
      #1;
      chk("final_idle", 32'(dma_busy), 32'(0));
      chk("done_cnt", 32'(done_cnt), 32'(6));
      chk("sb_drained", 32'(sb.size()), 32'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
